// File: rtl/seg7_pkg.sv
// Shared types and sizes for the seven-segment serial sequencer.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } seg7_state_t;

    // Bits per frame pushed into the board's shift-register chain.
    localparam int SEG7_BITS  = 64;
    // Bit counter width: must hold SEG7_BITS without wrapping.
    localparam int SEG7_CNT_W = 7;

endpackage : seg7_pkg

// File: rtl/seg7_tick_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV enabled cycles.
// A synchronous clear parks the count at zero so every phase starts full length.
module seg7_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick = enable && (cnt == TERM);

    // Count 0..CLK_DIV-1 while enabled, reload on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (enable) begin
            cnt <= (cnt == TERM) ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule : seg7_tick_gen

// File: rtl/seg7_serial_ctrl.sv
// Seven-segment serial sequencer: captures a 64-bit pattern, shifts it MSB
// first on a divided seg_clk, then pulses seg_pen and reports done.
// Optional feature macro: SEG7_AUTO_REFRESH_EN (periodic self-started refresh).
module seg7_serial_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEG7_BITS-1:0] pattern_i,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 seg_clk,
    output logic                 seg_sout,
    output logic                 seg_pen,
    output logic                 seg_clrn
);

    // Reject out-of-range configuration at elaboration time.
    if (CLK_DIV < 1 || CLK_DIV > 255 || REFRESH_CYCLES < 2) begin : g_param_chk
        $error("seg7_serial_ctrl: CLK_DIV must be 1..255 and REFRESH_CYCLES >= 2");
    end

    seg7_state_t            state, state_nxt;
    logic [SEG7_BITS-1:0]   shreg;
    logic [SEG7_CNT_W-1:0]  bitcnt;
    logic                   tick;
    logic                   req;
    logic                   refresh_hit;
    logic                   load;
    logic                   rise;
    logic                   fall;
    logic                   last_bit;
    logic                   latch_end;

    assign last_bit = (bitcnt == SEG7_CNT_W'(SEG7_BITS - 1));

    // The divider only runs during a transfer; in idle it is held at zero so
    // the first low phase after a start is a full CLK_DIV cycles.
    seg7_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state != ST_IDLE),
        .clear  (state == ST_IDLE),
        .tick   (tick)
    );

`ifdef SEG7_AUTO_REFRESH_EN
    localparam int REF_LOG = $clog2(REFRESH_CYCLES);
    localparam int REF_W   = (REF_LOG > 20) ? REF_LOG : 20;

    logic [REF_W-1:0] ref_cnt;

    assign refresh_hit = (state == ST_IDLE) && (ref_cnt == REF_W'(REFRESH_CYCLES - 1));

    // Idle-time counter; restarts after every completed or accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
        end else if (done || load) begin
            ref_cnt <= '0;
        end else if (state == ST_IDLE) begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // An external start and a refresh expiry in the same cycle give one transfer.
    assign req = start | refresh_hit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        latch_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_SHIFT;
                    load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!seg_clk) begin
                        rise = 1'b1;
                    end else begin
                        fall = 1'b1;
                        if (last_bit) begin
                            state_nxt = ST_LATCH;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                    latch_end = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and registered board outputs. Data only
    // moves on the falling transition, so seg_sout is settled a full half
    // period before each rising edge and held a full half period after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '1;
            bitcnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b1;
            seg_pen  <= 1'b0;
            seg_clrn <= 1'b0;
        end else begin
            seg_clrn <= 1'b1;
            done     <= latch_end;
            busy     <= (state_nxt != ST_IDLE);
            if (load) begin
                shreg    <= pattern_i;
                bitcnt   <= '0;
                seg_sout <= pattern_i[SEG7_BITS-1];
                seg_clk  <= 1'b0;
            end
            if (rise) begin
                seg_clk <= 1'b1;
            end
            if (fall) begin
                seg_clk  <= 1'b0;
                shreg    <= {shreg[SEG7_BITS-2:0], 1'b1};
                seg_sout <= shreg[SEG7_BITS-2];
                bitcnt   <= bitcnt + SEG7_CNT_W'(1);
                if (last_bit) begin
                    seg_pen <= 1'b1;
                end
            end
            if (latch_end) begin
                seg_pen <= 1'b0;
            end
        end
    end

endmodule : seg7_serial_ctrl

// File: tb/tb_seg7_serial_ctrl.sv
// Directed bench for seg7_serial_ctrl: reset state, frame timing and data,
// ignored mid-transfer requests, reset abort, and back-to-back at CLK_DIV=1.
module tb_seg7_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pattern_i = '0;
    logic        start = 1'b0;
    logic        busy, done, seg_clk, seg_sout, seg_pen, seg_clrn;

    logic [63:0] pattern1 = '0;
    logic        start1 = 1'b0;
    logic        busy1, done1, seg_clk1, seg_sout1, seg_pen1, seg_clrn1;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    seg7_serial_ctrl #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .pattern_i(pattern_i), .start(start),
        .busy(busy), .done(done), .seg_clk(seg_clk), .seg_sout(seg_sout),
        .seg_pen(seg_pen), .seg_clrn(seg_clrn)
    );

    seg7_serial_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pattern_i(pattern1), .start(start1),
        .busy(busy1), .done(done1), .seg_clk(seg_clk1), .seg_sout(seg_sout1),
        .seg_pen(seg_pen1), .seg_clrn(seg_clrn1)
    );

    // Board-side model: shift seg_sout in on each seg_clk rise, flag any data
    // change while seg_clk stays high. Runs on posedge, checks read on negedge.
    logic [63:0] cap = '0, cap1 = '0;
    int          rises = 0, rises1 = 0, viol = 0;
    logic        pclk = 1'b0, psout = 1'b1, pclk1 = 1'b0;

    always @(posedge clk) begin
        if (seg_clk && !pclk) begin
            cap   <= {cap[62:0], seg_sout};
            rises <= rises + 1;
        end
        if (seg_clk && pclk && (seg_sout != psout)) viol <= viol + 1;
        pclk  <= seg_clk;
        psout <= seg_sout;
        if (seg_clk1 && !pclk1) begin
            cap1   <= {cap1[62:0], seg_sout1};
            rises1 <= rises1 + 1;
        end
        pclk1 <= seg_clk1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer on dut; cycle c=1 is the cycle after the accepting edge.
    task automatic run_frame(input logic [63:0] pat, input bit disturb,
                             output int done_c, output int done_n,
                             output int pen_f, output int pen_l, output int pen_n,
                             output int rise_f, output int busy_c1, output int busy_dn);
        done_c = -1; done_n = 0; pen_f = -1; pen_l = -1; pen_n = 0;
        rise_f = -1; busy_c1 = 0; busy_dn = 1;
        @(negedge clk);
        pattern_i = pat;
        start = 1'b1;
        for (int c = 1; c <= 560; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy_c1 = int'(busy);
                start = 1'b0;
            end
            if (disturb && c == 90)  start = 1'b1;
            if (disturb && c == 91)  start = 1'b0;
            if (disturb && c == 200) pattern_i = ~pat;
            if (seg_clk && rise_f < 0) rise_f = c;
            if (seg_pen) begin
                pen_n++;
                if (pen_f < 0) pen_f = c;
                pen_l = c;
            end
            if (done) begin
                done_n++;
                if (done_c < 0) begin
                    done_c  = c;
                    busy_dn = int'(busy);
                end
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int dc, dn, pf, pl, pn, rf, b1, bd, r0;
        bit hit;
        int st [3];
        int rs [3];
        int nst;
        logic pb, got1;
        logic [63:0] cap1_first;

        // Reset state while rst_n is low.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_segclk", seg_clk, 0);
        chk("rst_sout", seg_sout, 1);
        chk("rst_pen", seg_pen, 0);
        chk("rst_clrn", seg_clrn, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("clrn_rise", seg_clrn, 1);
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_pen", seg_pen, 0);
        chk("idle_sout", seg_sout, 1);

        // Frame 1: timing and data.
        r0 = rises;
        run_frame(64'hFEDC_BA98_7654_3210, 1'b0, dc, dn, pf, pl, pn, rf, b1, bd);
        chk("f1_data", cap, 64'hFEDC_BA98_7654_3210);
        chk("f1_rises", rises - r0, 64);
        chk("f1_busy_c1", b1, 1);
        chk("f1_first_rise", rf, 5);
        chk("f1_pen_first", pf, 513);
        chk("f1_pen_last", pl, 516);
        chk("f1_pen_cnt", pn, 4);
        chk("f1_done_cyc", dc, 517);
        chk("f1_done_cnt", dn, 1);
        chk("f1_busy_at_done", bd, 0);

        // Frame 2: extra start and pattern change mid-transfer are ignored.
        r0 = rises;
        run_frame(64'hA5A5_0F0F_C3C3_FFFF, 1'b1, dc, dn, pf, pl, pn, rf, b1, bd);
        chk("f2_data", cap, 64'hA5A5_0F0F_C3C3_FFFF);
        chk("f2_rises", rises - r0, 64);
        chk("f2_done_cnt", dn, 1);
        chk("f2_done_cyc", dc, 517);

        // Reset at bit 30 of a transfer.
        @(negedge clk);
        pattern_i = 64'h0000_FFFF_0000_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r0 = rises;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (rises - r0 >= 30) hit = 1'b1;
        end
        chk("abort_reach_bit30", hit, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_segclk", seg_clk, 0);
        chk("abort_sout", seg_sout, 1);
        chk("abort_pen", seg_pen, 0);
        chk("abort_clrn", seg_clrn, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        r0 = rises;
        run_frame(64'h1357_9BDF_2468_ACE0, 1'b0, dc, dn, pf, pl, pn, rf, b1, bd);
        chk("post_abort_data", cap, 64'h1357_9BDF_2468_ACE0);
        chk("post_abort_rises", rises - r0, 64);
        chk("post_abort_done_cyc", dc, 517);

        // CLK_DIV=1, start held: transfers every 130 cycles.
        nst = 0; pb = 1'b0; got1 = 1'b0; cap1_first = '0;
        @(negedge clk);
        pattern1 = 64'hFEDC_BA98_7654_3210;
        start1 = 1'b1;
        for (int c = 1; c <= 420; c++) begin
            @(negedge clk);
            if (busy1 && !pb && nst < 3) begin
                st[nst] = c;
                rs[nst] = rises1;
                nst++;
            end
            pb = busy1;
            if (done1 && !got1) begin
                cap1_first = cap1;
                got1 = 1'b1;
            end
        end
        start1 = 1'b0;
        chk("b2b_starts", nst, 3);
        if (nst == 3) begin
            chk("b2b_gap1", st[1] - st[0], 130);
            chk("b2b_gap2", st[2] - st[1], 130);
            chk("b2b_rises1", rs[1] - rs[0], 64);
            chk("b2b_rises2", rs[2] - rs[1], 64);
        end
        chk("b2b_done_seen", got1, 1);
        chk("b2b_data", cap1_first, 64'hFEDC_BA98_7654_3210);

        chk("sout_hold_viol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule : tb_seg7_serial_ctrl

// File: doc/seg7_serial_ctrl.md
# seg7_serial_ctrl

Sequencer that ships a 64-bit seven-segment pattern from the display decoder to the board's chain of serial-in/parallel-out shift registers. It captures `pattern_i` on a start request and shifts it out MSB first on a divided serial clock. It then pulses the output-latch/enable line and reports completion. It sits between the seven-segment decoder output and the board pins `seg_clk`/`seg_sout`/`seg_pen`/`seg_clrn`.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per half period of `seg_clk`; legal range 1..255.
- `REFRESH_CYCLES`, default 1_000_000: idle cycles between automatic refreshes; used only with `SEG7_AUTO_REFRESH_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pattern_i` in 64: active-low segment pattern; bit 63 leaves the block first.
- `start` in 1: request one transfer; level-sampled.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes.
- `seg_clk` out 1: serial shift clock to the board.
- `seg_sout` out 1: serial data; stable across every `seg_clk` rising edge.
- `seg_pen` out 1: parallel latch/output-enable; high for `CLK_DIV` cycles after the last bit.
- `seg_clrn` out 1: shift-register clear, active low.

## Operation
- FSM states:
  - `ST_IDLE`: `start`=1 (or, with the macro, a refresh expiry) loads `pattern_i` into a 64-bit shift register and sets bit count = 0. Next state is `ST_SHIFT`.
  - `ST_SHIFT`: for each bit, `seg_clk` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
    - `seg_sout` = shreg[63], updated on the cycle `seg_clk` falls (and at entry).
    - The shift register moves left by one on each falling transition.
    - After 64 bits, the next state is `ST_LATCH`.
  - `ST_LATCH`: `seg_pen`=1 and `seg_clk`=0 for `CLK_DIV` cycles. Next state is `ST_IDLE`, with `done`=1 for exactly that first `ST_IDLE` cycle.
- `busy` = (state != `ST_IDLE`).
- `start` while `busy` is ignored. Requests are not queued.
- `pattern_i` is sampled only at the accepting edge. Later changes do not affect an ongoing transfer.
- `start` held high in the `done` cycle is accepted, which gives back-to-back transfers with a single idle cycle between them.
- Bit counter is 7 bits; it terminates at 64 and does not wrap.
- Half-period counter is 8 bits; it reloads at `CLK_DIV-1` and generates a `tick` on terminal count.

## Timing
- Reset values: state `ST_IDLE`, `busy`=0, `done`=0, `seg_clk`=0, `seg_sout`=1, `seg_pen`=0, `seg_clrn`=0.
- `seg_clrn` rises in the first `clk` cycle after `rst_n` deasserts and stays high thereafter.
- Start accepted at edge k:
  - `busy`=1 from cycle k+1.
  - First `seg_clk` rise at k+1+`CLK_DIV`.
  - `ST_SHIFT` lasts 128·`CLK_DIV` cycles.
  - `seg_pen` is high during cycles k+1+128·`CLK_DIV` .. k+129·`CLK_DIV`.
  - `done`=1 and `busy`=0 at k+1+129·`CLK_DIV`. With the default `CLK_DIV`=4, that is k+517.
- `seg_sout` changes only while `seg_clk` is low. It gives `CLK_DIV` cycles of setup and `CLK_DIV` cycles of hold around each rising edge.
- Reset mid-transfer: all outputs immediately take their reset values and the transfer is discarded. The board chain is cleared via `seg_clrn`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SEG7_AUTO_REFRESH_EN`.
- Defined:
  - A refresh counter of 20+ bits, sized for `REFRESH_CYCLES`, counts in `ST_IDLE`. It resets to 0 on `done` and on any accepted start.
  - Reaching `REFRESH_CYCLES`-1 generates an internal start.
  - An external `start` in the same cycle merges with it, giving one transfer.
  - The first automatic transfer begins `REFRESH_CYCLES` cycles after reset release.
- Undefined:
  - Transfers occur only on external `start`.
  - The refresh counter and `REFRESH_CYCLES` are absent from the synthesized logic.

## Structure
- Shared package `seg7_pkg` holds:
  - The state enum (`ST_IDLE`, `ST_SHIFT`, `ST_LATCH`).
  - `SEG7_BITS` = 64.
  - `SEG7_CNT_W` = 7.
- One sub-module, `seg7_tick_gen`:
  - Half-period divider with `enable` and synchronous `clear`.
  - Outputs a one-cycle `tick`.
  - Parameter `CLK_DIV`.
- The FSM, shift register, bit counter and refresh counter stay in `seg7_serial_ctrl`.

## Test plan
- Reset release, no start → `seg_clrn` 0→1 after one cycle; `busy`, `done`, `seg_pen` remain 0; `seg_sout`=1.
- `pattern_i`=64'hFEDC_BA98_7654_3210, `CLK_DIV`=4, start at cycle 10:
  - A model sampling `seg_sout` on each `seg_clk` rise reconstructs the value MSB first.
  - `done` pulses at cycle 527.
  - `seg_pen` is high during cycles 523..526.
- `start` pulsed again at cycle 100 and `pattern_i` changed mid-transfer → both are ignored; shifted data equals the original pattern; exactly one `done`.
- `start` held high continuously, `CLK_DIV`=1 → successive transfers begin every 130 cycles; exactly 64 `seg_clk` rises per transfer.
- `rst_n` asserted at bit 30 → all outputs at reset values in the same cycle. A new start after release produces a complete, correct 64-bit frame.
- `SEG7_AUTO_REFRESH_EN`, `REFRESH_CYCLES`=1000, no external start → first transfer begins 1000 cycles after reset. The next begins 1000 cycles after each `done`.
